// File: rtl/fpu_mult_ostage.sv
// fpu_mult_ostage: registered output stage behind the combinational IEEE-754
// single-precision multiplier. It classifies each product and canonicalises
// invalid results to a quiet NaN. Results wait in a DEPTH-entry FIFO with a
// valid/ready handshake. The stage also keeps sticky exception flags and a
// count of popped results.
// Optional build macro FPU_MULT_FTZ_EN: when defined, denormal results are
// flushed to a signed zero and flagged as zero and underflow.
module fpu_mult_ostage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    input  logic [31:0]              in_s,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [4:0]               out_flags,
    output logic [4:0]               sticky_flags,
    input  logic                     flag_clr,
    output logic [CNT_W-1:0]         res_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Entry layout: {invalid, overflow, underflow, inf, zero, data[31:0]}
    function automatic logic [36:0] classify(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] s
    );
        logic a_max, b_max, s_max, a_emin, b_emin, s_emin;
        logic a_nan, b_nan, s_nan, a_inf, b_inf, s_inf, a_zero, b_zero;
        logic a_nzfin, b_nzfin, sgn, invalid;
        logic ovf, unf, inf, zero;
        logic [31:0] data;
        a_max   = (a[30:23] == 8'hFF);
        b_max   = (b[30:23] == 8'hFF);
        s_max   = (s[30:23] == 8'hFF);
        a_emin  = (a[30:23] == 8'h00);
        b_emin  = (b[30:23] == 8'h00);
        s_emin  = (s[30:23] == 8'h00);
        a_nan   = a_max & (a[22:0] != 23'd0);
        b_nan   = b_max & (b[22:0] != 23'd0);
        s_nan   = s_max & (s[22:0] != 23'd0);
        a_inf   = a_max & (a[22:0] == 23'd0);
        b_inf   = b_max & (b[22:0] == 23'd0);
        s_inf   = s_max & (s[22:0] == 23'd0);
        a_zero  = a_emin & (a[22:0] == 23'd0);
        b_zero  = b_emin & (b[22:0] == 23'd0);
        a_nzfin = ~a_max & ~a_zero;
        b_nzfin = ~b_max & ~b_zero;
        sgn     = a[31] ^ b[31];
        // A NaN product from non-NaN operands is also reported as invalid
        invalid = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf) | s_nan;
        if (invalid) begin
            data = QNAN;
            ovf  = 1'b0;
            unf  = 1'b0;
            inf  = 1'b0;
            zero = 1'b0;
        end else begin
            data = {sgn, s[30:0]};
            inf  = s_inf;
            ovf  = s_inf & ~a_max & ~b_max;
            zero = (s[30:0] == 31'd0);
            unf  = s_emin & a_nzfin & b_nzfin;
`ifdef FPU_MULT_FTZ_EN
            if (s_emin && (s[22:0] != 23'd0)) begin
                data = {sgn, 31'd0};
                zero = 1'b1;
                unf  = 1'b1;
            end else begin
                data = {sgn, s[30:0]};
            end
`endif
        end
        return {invalid, ovf, unf, inf, zero, data};
    endfunction

    logic [36:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [4:0]    sticky_r;
    logic [CNT_W-1:0] count_r;
    logic [36:0]   entry_s;
    logic [36:0]   head_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;

    // Classify the incoming product and form handshake strobes
    always_comb begin
        entry_s = classify(in_a, in_b, in_s);
        full_s  = (level_r == LW'(DEPTH));
        empty_s = (level_r == LW'(0));
        push_s  = in_valid & ~full_s;
        pop_s   = out_ready & ~empty_s;
        head_s  = mem_r[rd_ptr_r];
    end

    // Drive head outputs, forced to zero when the FIFO is empty
    always_comb begin
        if (empty_s) begin
            out_data  = 32'h0000_0000;
            out_flags = 5'b00000;
        end else begin
            out_data  = head_s[31:0];
            out_flags = head_s[36:32];
        end
    end

    assign in_ready     = ~full_s;
    assign out_valid    = ~empty_s;
    assign level        = level_r;
    assign sticky_flags = sticky_r;
    assign res_count    = count_r;

    // FIFO storage: write the classified entry at the tail on push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 37'd0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers wrap naturally modulo DEPTH; level tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            level_r  <= LW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky flags accumulate popped flags; clear takes effect before the OR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= 5'b00000;
        end else if (pop_s) begin
            sticky_r <= (flag_clr ? 5'b00000 : sticky_r) | head_s[36:32];
        end else if (flag_clr) begin
            sticky_r <= 5'b00000;
        end else begin
            sticky_r <= sticky_r;
        end
    end

    // Result counter counts pops and wraps at its width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_W'(0);
        end else if (pop_s) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: doc/fpu_mult_ostage.md
Name: fpu_mult_ostage

Overview:
- Registered output stage directly downstream of the combinational single-precision IEEE-754 `multiplier`.
- Captures the product S together with operands A and B, and classifies the result.
- Canonicalises invalid results to a quiet NaN and buffers them in a small FIFO with valid/ready handshake.
- Maintains sticky exception flags and a result counter for the FPAU status path.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CNT_W, 16, width of the result counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream has a product
- in_ready  output  1  stage can accept
- in_a  input  32  multiplier operand A
- in_b  input  32  multiplier operand B
- in_s  input  32  multiplier result S
- out_valid  output  1  FIFO head valid
- out_ready  input  1  downstream accepts
- out_data  output  32  final result
- out_flags  output  5  {invalid, overflow, underflow, inf, zero} of head entry
- sticky_flags  output  5  OR of flags of all popped results
- flag_clr  input  1  clear sticky_flags
- res_count  output  CNT_W  number of popped results
- level  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): pointers, level, sticky_flags and res_count go to 0. out_valid=0, in_ready=1, out_data=0, out_flags=0.
- Push on in_valid&&in_ready. Pop on out_valid&&out_ready.
- in_ready = (level!=DEPTH). There is no pass-through when full: a simultaneous push and pop while full is impossible because in_ready=0.
- Latency: an entry pushed at edge N is visible on out_valid/out_data after edge N. Minimum latency is 1 cycle and there is no combinational in→out path.
- Simultaneous push and pop when not full and not empty: level is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- out_valid = (level!=0). When empty, out_data=0 and out_flags=0.
- Classification is computed combinationally from in_a/in_b/in_s at push time and stored with the entry.
  - Fields: exp = bits[30:23], man = bits[22:0]. NaN: exp=FF, man≠0. Inf: exp=FF, man=0. Zero: exp=0, man=0.
  - sgn = in_a[31]^in_b[31].
  - invalid = (A or B is NaN) | (A inf & B zero) | (A zero & B inf). When invalid, data=32'h7FC00000 and all other flags are 0.
  - Otherwise data = {sgn, in_s[30:0]}; the sign is always forced from the operands.
  - inf = in_s is inf.
  - overflow = inf & A finite & B finite.
  - zero = in_s[30:0]==0.
  - underflow = (in_s exp==0) & A nonzero finite & B nonzero finite.
  - An in_s that is NaN but not invalid is treated as invalid: data=7FC00000, flag invalid.
- Sticky flags:
  - On a pop: sticky_flags <= (flag_clr ? 0 : sticky_flags) | out_flags.
  - flag_clr with no pop: sticky_flags <= 0.
- res_count increments on each pop and wraps from 2^CNT_W-1 to 0.
- level updates: +1 on push only, -1 on pop only.
- Reset asserted mid-operation discards all entries immediately. The first push after rst_n rises is accepted normally.

Optional Feature:
- Macro FPU_MULT_FTZ_EN.
- Defined: a non-invalid result with exp=0 and man≠0 is flushed to {sgn,31'b0}, with zero=1 and underflow=1.
- Undefined: the denormal passes unchanged, zero=0, and underflow is set per the rule above.

Test Plan:
- A=C1CC0000, B=C1CAC000, S=44219100, out_ready=1 → one cycle later out_data=44219100, out_flags=0, res_count=1.
- A=7F800000, B=00000000, S=any → out_data=7FC00000, out_flags=10000. Then A=B=7F800000, S=7F800000 → out_data=7F800000, out_flags=00010 (no overflow).
- A=7F000000, B=40000000, S=7F800000 → out_flags=01010. A=00800000, B=00800000, S=00000000 → out_data=00000000, out_flags=00101.
- out_ready=0, push 5 valid products → 4 accepted, in_ready=0 after the 4th, level=4. Raise out_ready → the 4 entries drain in push order and in_ready returns to 1 after the first pop.
- Pop invalid then overflow results → sticky_flags=11010. Pulse flag_clr alone → 00000. flag_clr coincident with pop of a zero result → 00001.
- With level=3, assert rst_n=0 for 1 cycle → level=0, out_valid=0, counters 0. Next push with S=3F800000, A=B=3F800000 → out_data=3F800000.
